key_debounce_pulse: RTL and testbench
=====================================

# key_debounce_pulse

Front-end conditioning stage for the board's push-buttons. It takes the raw, bouncing, asynchronous `swb` button levels and produces clean debounced levels plus single-cycle press, release and long-press pulses, all on `clk`. The board-level operand-loading and display-select logic consumes these pulses as clock-domain strobes instead of clocking on raw `posedge swb[i]`. It also provides optional per-key auto-repeat for stepping through values.

## Interface
- `N`, 6 — number of keys.
- `DEB_CYC`, 1_000_000 — consecutive stable synchronized cycles required to accept a level change (10 ms @ 100 MHz). Must be ≥ 2.
- `HOLD_CYC`, 50_000_000 — cycles the debounced level must stay high before the long-press event.
- `REP_CYC`, 10_000_000 — auto-repeat period after the long-press event.
- `REP_MASK`, {N{1'b0}} — per-key auto-repeat enable, bit i ↔ key i.
- `clk` input 1 — system clock; single clock domain.
- `Rst` input 1 — synchronous, active-high reset.
- `key_raw` input [N:1] — raw button levels, asynchronous, 1 = pressed.
- `key_level` output [N:1] — debounced level.
- `key_press` output [N:1] — 1-cycle pulse on an accepted press and on each auto-repeat.
- `key_release` output [N:1] — 1-cycle pulse on an accepted release.
- `key_long` output [N:1] — 1-cycle pulse when the held time reaches `HOLD_CYC`.

## Operation
- Each key is fully independent; keys share no state.
- Synchronizer: 2 flops per key; `s` = second flop.
- Debounce counter `dcnt`, width $clog2(DEB_CYC):
  - If `s == key_level`, then `dcnt <= 0`.
  - Otherwise, if `dcnt == DEB_CYC-1`, then `key_level <= s` and `dcnt <= 0`.
  - Otherwise, `dcnt <= dcnt+1`.
  - Any return of `s` to `key_level` restarts the count, so glitches shorter than `DEB_CYC` cycles are fully rejected.
- Per-key FSM, states IDLE / HELD / REPEAT, with hold counter `hcnt`:
  - IDLE: on the `key_level` 0→1 transition, pulse `key_press`, set `hcnt <= 0`, go to HELD.
  - HELD: `hcnt` increments each cycle. When `hcnt == HOLD_CYC-1`:
    - pulse `key_long`;
    - if `REP_MASK[i]` is set, also pulse `key_press`, set `hcnt <= 0`, go to REPEAT;
    - otherwise stay in HELD with `hcnt` saturated (no further events).
  - REPEAT: `hcnt` counts to `REP_CYC-1`, then pulses `key_press`, sets `hcnt <= 0`, and repeats.
  - In any non-IDLE state, the `key_level` 1→0 transition pulses `key_release`, goes to IDLE and sets `hcnt <= 0`. Release takes priority over a long or repeat event due in the same cycle: that event is suppressed.
- All outputs are registered. Every pulse is exactly 1 cycle wide.
- Reset:
  - Synchronizer flops, `dcnt`, `hcnt` and all outputs go to 0; FSM goes to IDLE.
  - A reset asserted mid-hold produces no `key_release`.
  - A key still held after reset is treated as a fresh press once debounced.

## Timing
- Reset values: `key_level`, `key_press`, `key_release` and `key_long` are all 0, visible after the first edge with `Rst`=1.
- Press latency: take the first edge that samples `key_raw`=1 as edge 1. `key_level` and `key_press` go high after edge `DEB_CYC+2`, provided `key_raw` stays stable. Release latency is identical.
- `key_long`: with `key_level` rising after edge L, `key_long` is high after edge L+`HOLD_CYC`.
- Auto-repeat (masked keys): `key_press` pulses after L, L+`HOLD_CYC`, L+`HOLD_CYC`+`REP_CYC`, L+`HOLD_CYC`+2·`REP_CYC`, and so on.
- Minimum spacing between accepted events on one key is `DEB_CYC` cycles. Press and release pulses of one key never coincide.
- Simultaneous events on different keys are all reported in the same cycle.
- Counter wrap: `hcnt` never wraps; it saturates in HELD.

## Test plan
All scenarios use `N`=6, `DEB_CYC`=4, `HOLD_CYC`=20, `REP_CYC`=5, `REP_MASK`=6'b000100.

1. Reset: `Rst`=1 for 3 cycles with `key_raw`=6'h3F → all outputs 0. After release of `Rst`, `key_level`=6'h3F after edge 6 and `key_press`=6'h3F for exactly 1 cycle.
2. Clean press: key 1 goes high before edge 1 and stays high → `key_level[1]`/`key_press[1]` high after edge 6, `key_press[1]` low after edge 7, `key_long[1]` after edge 26, and no repeats.
3. Glitch rejection: key 2 high for 3 cycles, then low → `key_level[2]`, `key_press[2]` and `key_release[2]` remain 0 throughout.
4. Bounce: key 4 toggles every 2 cycles for 12 cycles, then stays high → exactly one `key_press[4]`, 6 edges after the final transition. A mirrored bounce on release gives exactly one `key_release[4]`.
5. Auto-repeat: key 3 held (level rises after edge L) → `key_long[3]` and `key_press[3]` at L+20, then `key_press[3]` at L+25 and L+30. Releasing key 3 → one `key_release[3]` and no further presses. Simultaneous hold of key 5 → `key_long[5]` only.
6. Reset mid-hold: key 3 in REPEAT, `Rst` pulsed for 1 cycle → all outputs 0 and no `key_release`. Key still held → `key_press[3]` 6 edges after `Rst` deasserts.

Source files
------------

// File: rtl/key_debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pulse_if
// Brief    : Key bundle between the raw push-buttons and their consumers.
//            Carries the raw levels in and the debounced level and event
//            pulses out, one bit per key, keys numbered 1..N.
// Revision : 1.0 - initial release
// ============================================================================
interface key_debounce_pulse_if #(
  parameter int N = 6
) ();

  logic [N:1] key_raw;
  logic [N:1] key_level;
  logic [N:1] key_press;
  logic [N:1] key_release;
  logic [N:1] key_long;

  // Board side: drives the raw buttons and consumes the events
  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  // Conditioning block side
  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );

endinterface
`default_nettype wire

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pulse
// Brief    : Per-key synchronizer, debouncer and press/release/long-press
//            event generator with optional auto-repeat. Keys are fully
//            independent; every output is registered.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_pulse #(
  parameter int         N        = 6,
  parameter int         DEB_CYC  = 1_000_000,
  parameter int         HOLD_CYC = 50_000_000,
  parameter int         REP_CYC  = 10_000_000,
  parameter logic [N:1] REP_MASK = '0
) (
  input  wire logic             clk,
  input  wire logic             Rst,
  key_debounce_pulse_if.slave   bus
);

  localparam int DW   = $clog2(DEB_CYC);
  localparam int HMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  for (genvar i = 1; i <= N; i++) begin : g_key
    logic          sync1;
    logic          s;
    logic          level;
    logic [DW-1:0] dcnt;
    logic          accept;
    logic          rise;
    logic          fall;
    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic          press_nx;
    logic          rel_nx;
    logic          long_nx;
    logic          press_q;
    logic          rel_q;
    logic          long_q;

    // A level change is accepted on the edge that completes DEB_CYC
    // consecutive mismatching samples; the FSM sees it on that same edge so
    // the pulse lines up with the new debounced level.
    assign accept = (s != level) && (dcnt == DEB_LAST);
    assign rise   = accept &  s;
    assign fall   = accept & ~s;

    // Two-flop synchronizer followed by the restartable debounce counter
    always_ff @(posedge clk) begin
      if (Rst) begin
        sync1 <= 1'b0;
        s     <= 1'b0;
        level <= 1'b0;
        dcnt  <= '0;
      end else begin
        sync1 <= bus.key_raw[i];
        s     <= sync1;
        if (s == level) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          level <= s;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + DCNT_ONE;
        end
      end
    end

    // Event FSM state, hold counter and registered pulses
    always_ff @(posedge clk) begin
      if (Rst) begin
        state   <= ST_IDLE;
        hcnt    <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state   <= state_nx;
        hcnt    <= hcnt_nx;
        press_q <= press_nx;
        rel_q   <= rel_nx;
        long_q  <= long_nx;
      end
    end

    // Next state and pulses; a release beats any long/repeat event due now
    always_comb begin
      state_nx = state;
      hcnt_nx  = hcnt;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      long_nx  = 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            press_nx = 1'b1;
            hcnt_nx  = '0;
            state_nx = ST_HELD;
          end
        end
        ST_HELD: begin
          if (fall) begin
            rel_nx   = 1'b1;
            hcnt_nx  = '0;
            state_nx = ST_IDLE;
          end else if (hcnt == HOLD_LAST) begin
            long_nx = 1'b1;
            if (REP_MASK[i]) begin
              press_nx = 1'b1;
              hcnt_nx  = '0;
              state_nx = ST_REPEAT;
            end else begin
              // Parked past the trigger value so the long event fires once
              hcnt_nx = HOLD_SAT;
            end
          end else if (hcnt < HOLD_LAST) begin
            hcnt_nx = hcnt + HCNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            rel_nx   = 1'b1;
            hcnt_nx  = '0;
            state_nx = ST_IDLE;
          end else if (hcnt == REP_LAST) begin
            press_nx = 1'b1;
            hcnt_nx  = '0;
          end else begin
            hcnt_nx = hcnt + HCNT_ONE;
          end
        end
        default: begin
          hcnt_nx  = '0;
          state_nx = ST_IDLE;
        end
      endcase
    end

    assign bus.key_level[i]   = level;
    assign bus.key_press[i]   = press_q;
    assign bus.key_release[i] = rel_q;
    assign bus.key_long[i]    = long_q;
  end : g_key

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_pulse
// Brief    : Directed scenarios plus randomized button activity, compared
//            each cycle against a window-based reference model of the keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_pulse;

  localparam int         N    = 6;
  localparam int         DEB  = 4;
  localparam int         HOLD = 20;
  localparam int         REP  = 5;
  localparam logic [N:1] MASK = 6'b000100;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  key_debounce_pulse_if #(.N(N)) bus ();

  key_debounce_pulse #(
    .N        (N),
    .DEB_CYC  (DEB),
    .HOLD_CYC (HOLD),
    .REP_CYC  (REP),
    .REP_MASK (MASK)
  ) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Reference model: raw sample history and per-key hold bookkeeping
  logic [N:1] hist[$];
  logic [N:1] m_level, m_press, m_rel, m_long;
  bit         held[1:N];
  int         since[1:N];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int cnt_press[1:N];
  int cnt_rel[1:N];
  int cnt_long[1:N];

  logic [N:1] rnd_raw;
  int         run_left[1:N];

  task automatic check(input string tag, input logic [N:1] obs, input logic [N:1] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A level is accepted at edge t when the DEB raw samples taken at edges
  // t-DEB-1 .. t-2 all agree and differ from the current level.
  task automatic model_step(input logic [N:1] raw, input logic rst_v);
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    if (rst_v) begin
      hist.delete();
      repeat (DEB + 2) hist.push_back('0);
      m_level = '0;
      for (int i = 1; i <= N; i++) begin
        held[i]  = 1'b0;
        since[i] = 0;
      end
    end else begin
      hist.push_back(raw);
      void'(hist.pop_front());
      for (int i = 1; i <= N; i++) begin
        logic v;
        bit   stable;
        v      = hist[0][i];
        stable = 1'b1;
        for (int k = 1; k < DEB; k++)
          if (hist[k][i] !== v) stable = 1'b0;
        if (stable && (v !== m_level[i])) begin
          m_level[i] = v;
          if (v) begin
            m_press[i] = 1'b1;
            held[i]    = 1'b1;
            since[i]   = 0;
          end else begin
            m_rel[i] = 1'b1;
            held[i]  = 1'b0;
          end
        end else if (held[i]) begin
          since[i]++;
          if (since[i] == HOLD) m_long[i] = 1'b1;
          if (MASK[i] && since[i] >= HOLD && ((since[i] - HOLD) % REP) == 0)
            m_press[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic clr_cnt();
    for (int i = 1; i <= N; i++) begin
      cnt_press[i] = 0;
      cnt_rel[i]   = 0;
      cnt_long[i]  = 0;
    end
  endtask

  // One clock: drive on the falling edge, model on the rising edge, sample 1 ns later
  task automatic tick(input logic [N:1] raw, input logic rst_v);
    @(negedge clk);
    bus.key_raw = raw;
    Rst         = rst_v;
    @(posedge clk);
    model_step(raw, rst_v);
    #1;
    check("level",   bus.key_level,   m_level);
    check("press",   bus.key_press,   m_press);
    check("release", bus.key_release, m_rel);
    check("long",    bus.key_long,    m_long);
    for (int i = 1; i <= N; i++) begin
      if (bus.key_press[i])   cnt_press[i]++;
      if (bus.key_release[i]) cnt_rel[i]++;
      if (bus.key_long[i])    cnt_long[i]++;
    end
  endtask

  initial begin
    Rst         = 1'b1;
    bus.key_raw = '0;
    m_level     = '0;
    clr_cnt();

    // Reset with every key pressed, then release reset
    for (int e = 1; e <= 3; e++) tick(6'h3F, 1'b1);
    check("rst_level", bus.key_level, 6'h00);
    check("rst_press", bus.key_press, 6'h00);
    for (int e = 1; e <= 8; e++) begin
      tick(6'h3F, 1'b0);
      if (e == 5) check("p1_level_e5", bus.key_level, 6'h00);
      if (e == 6) begin
        check("p1_level_e6", bus.key_level, 6'h3F);
        check("p1_press_e6", bus.key_press, 6'h3F);
      end
      if (e == 7) check("p1_press_e7", bus.key_press, 6'h00);
    end
    // Reset while held: no release events
    clr_cnt();
    for (int e = 1; e <= 3; e++) tick(6'h00, 1'b1);
    for (int e = 1; e <= 8; e++) tick(6'h00, 1'b0);
    check_int("p1_no_release", cnt_rel[1] + cnt_rel[3] + cnt_rel[6], 0);

    // Clean press on key 1
    clr_cnt();
    for (int e = 1; e <= 40; e++) begin
      tick(6'b000001, 1'b0);
      if (e == 6) check("p2_press_e6", bus.key_press & 6'b000001, 6'b000001);
      if (e == 7) check("p2_press_e7", bus.key_press & 6'b000001, 6'b000000);
      if (e == 26) check("p2_long_e26", bus.key_long & 6'b000001, 6'b000001);
    end
    check_int("p2_press_count", cnt_press[1], 1);
    check_int("p2_long_count", cnt_long[1], 1);
    for (int e = 1; e <= 10; e++) tick(6'h00, 1'b0);

    // Glitch on key 2 shorter than the debounce window
    clr_cnt();
    for (int e = 1; e <= 3; e++) tick(6'b000010, 1'b0);
    for (int e = 1; e <= 10; e++) tick(6'h00, 1'b0);
    check_int("p3_glitch_events", cnt_press[2] + cnt_rel[2], 0);

    // Bounce on key 4 press and release
    clr_cnt();
    for (int e = 0; e < 12; e++) tick((e % 4 < 2) ? 6'b001000 : 6'b000000, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick(6'b001000, 1'b0);
      if (e == 6) check("p4_press_e6", bus.key_press & 6'b001000, 6'b001000);
    end
    for (int e = 0; e < 12; e++) tick((e % 4 < 2) ? 6'b000000 : 6'b001000, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick(6'b000000, 1'b0);
      if (e == 6) check("p4_release_e6", bus.key_release & 6'b001000, 6'b001000);
    end
    check_int("p4_press_count", cnt_press[4], 1);
    check_int("p4_release_count", cnt_rel[4], 1);

    // Auto-repeat on key 3 alongside plain hold of key 5; release lands on a repeat slot
    clr_cnt();
    for (int e = 1; e <= 55; e++) begin
      tick((e <= 35) ? 6'b010100 : 6'b000000, 1'b0);
      if (e == 26) begin
        check("p5_long_e26", bus.key_long, 6'b010100);
        check("p5_press_e26", bus.key_press, 6'b000100);
      end
      if (e == 31) check("p5_press_e31", bus.key_press, 6'b000100);
      if (e == 36) check("p5_press_e36", bus.key_press, 6'b000100);
      if (e == 41) begin
        check("p5_release_e41", bus.key_release, 6'b010100);
        check("p5_press_e41", bus.key_press, 6'b000000);
      end
    end
    check_int("p5_press3_count", cnt_press[3], 4);
    check_int("p5_long3_count", cnt_long[3], 1);
    check_int("p5_press5_count", cnt_press[5], 1);
    check_int("p5_long5_count", cnt_long[5], 1);
    check_int("p5_release3_count", cnt_rel[3], 1);

    // Reset while key 3 is repeating
    for (int e = 1; e <= 30; e++) tick(6'b000100, 1'b0);
    clr_cnt();
    tick(6'b000100, 1'b1);
    check("p6_rst_level", bus.key_level, 6'h00);
    check("p6_rst_press", bus.key_press, 6'h00);
    for (int e = 1; e <= 12; e++) begin
      tick(6'b000100, 1'b0);
      if (e == 5) check("p6_press_e5", bus.key_press, 6'b000000);
      if (e == 6) check("p6_press_e6", bus.key_press, 6'b000100);
    end
    check_int("p6_no_release", cnt_rel[3], 0);
    for (int e = 1; e <= 10; e++) tick(6'h00, 1'b0);

    // Randomized button activity with occasional resets
    rnd_raw = '0;
    for (int i = 1; i <= N; i++) run_left[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 1; i <= N; i++) begin
        if (run_left[i] == 0) begin
          rnd_raw[i]  = ~rnd_raw[i];
          run_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(4, 45));
        end else begin
          run_left[i]--;
        end
      end
      tick(rnd_raw, ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
